alu_seq_ctrl: RTL

- Multi-cycle controller that sequences the register-file/ALU datapath: regFile, the ALUSrc operand mux and the 1-bit-control ALU.
- Accepts ALU commands over a valid/ready interface into a small FIFO and drives the datapath's read addresses, mux select, ALU control and write-back.
- Supports a repeat count, so one command performs an accumulate loop, e.g. ADDI x5,x5,1 issued N times.
- Reports completion with the final result and eq flag.

---
 rtl/alu_seq_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the regfile/ALU datapath: queues ALU commands in a small FIFO
// and steps each through EXEC/WB (optionally repeated) before pulsing done.
module alu_seq_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REP_W         = 8,
  parameter int unsigned Data_Width    = 32,
  parameter int unsigned Address_Width = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [Address_Width-1:0]      cmd_rs1,
  input  logic [Address_Width-1:0]      cmd_rs2,
  input  logic [Address_Width-1:0]      cmd_rd,
  input  logic [Data_Width-1:0]         cmd_imm,
  input  logic [REP_W-1:0]              cmd_rep,
  output logic [Address_Width-1:0]      rs1,
  output logic [Address_Width-1:0]      rs2,
  output logic [Address_Width-1:0]      rd,
  output logic                          en,
  output logic [Data_Width-1:0]         din,
  output logic                          ALUSrc,
  output logic [Data_Width-1:0]         ImmOp,
  output logic                          ALU_ctrl,
  input  logic [Data_Width-1:0]         ALUout,
  input  logic                          eq,
  output logic                          busy,
  output logic                          done,
  output logic [Data_Width-1:0]         done_result,
  output logic                          done_eq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] OpAdd  = 2'b00;
  localparam logic [1:0] OpSub  = 2'b01;
  localparam logic [1:0] OpAddi = 2'b10;
  localparam logic [1:0] OpCmp  = 2'b11;

  typedef struct packed {
    logic [1:0]               op;
    logic [Address_Width-1:0] rs1;
    logic [Address_Width-1:0] rs2;
    logic [Address_Width-1:0] rd;
    logic [Data_Width-1:0]    imm;
    logic [REP_W-1:0]         rep;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StExec, StWb, StDone} state_e;

  cmd_t                  mem_q [FIFO_DEPTH];
  cmd_t                  cmd_in;
  cmd_t                  head;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push, pop;

  state_e                state_q;
  logic [1:0]            op_q;
  logic [REP_W-1:0]      iter_q;
  logic [Data_Width-1:0] res_q;
  logic                  eqr_q;

  logic [Address_Width-1:0] rs1_q, rs2_q, rd_q;
  logic                     en_q, alusrc_q, aluctrl_q, done_q, done_eq_q;
  logic [Data_Width-1:0]    din_q, imm_q, done_result_q;

  assign cmd_in = '{op: cmd_op, rs1: cmd_rs1, rs2: cmd_rs2, rd: cmd_rd, imm: cmd_imm,
                    rep: cmd_rep};
  assign head   = mem_q[rd_ptr_q];

  assign cmd_ready = (count_q != CntW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == StIdle) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= StIdle;
      op_q          <= OpAdd;
      iter_q        <= '0;
      res_q         <= '0;
      eqr_q         <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      en_q          <= 1'b0;
      din_q         <= '0;
      alusrc_q      <= 1'b0;
      imm_q         <= '0;
      aluctrl_q     <= 1'b0;
      done_q        <= 1'b0;
      done_result_q <= '0;
      done_eq_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            op_q      <= head.op;
            rs1_q     <= head.rs1;
            rs2_q     <= head.rs2;
            rd_q      <= head.rd;
            imm_q     <= head.imm;
            alusrc_q  <= (head.op == OpAddi);
            aluctrl_q <= (head.op == OpSub) || (head.op == OpCmp);
            // CMP ignores its repeat field; a zero count still means one pass.
            iter_q    <= ((head.op == OpCmp) || (head.rep == '0)) ? REP_W'(1) : head.rep;
            state_q   <= StExec;
          end
        end
        StExec: begin
          res_q <= ALUout;
          eqr_q <= eq;
          if (op_q == OpCmp) begin
            done_q        <= 1'b1;
            done_result_q <= ALUout;
            done_eq_q     <= eq;
            state_q       <= StDone;
          end else begin
            en_q    <= (rd_q != '0);
            din_q   <= ALUout;
            state_q <= StWb;
          end
        end
        StWb: begin
          en_q   <= 1'b0;
          iter_q <= iter_q - REP_W'(1);
          if (iter_q == REP_W'(1)) begin
            done_q        <= 1'b1;
            done_result_q <= res_q;
            done_eq_q     <= eqr_q;
            state_q       <= StDone;
          end else begin
            state_q <= StExec;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign en          = en_q;
  assign din         = din_q;
  assign ALUSrc      = alusrc_q;
  assign ImmOp       = imm_q;
  assign ALU_ctrl    = aluctrl_q;
  assign done        = done_q;
  assign done_result = done_result_q;
  assign done_eq     = done_eq_q;
  assign fifo_count  = count_q;
  assign busy        = (state_q != StIdle) || (count_q != '0);

endmodule
